alu_issue_queue: RTL and testbench



---
 rtl/alu_issue_queue.sv | 126 ++++++++++++
 tb/tb_alu_issue_queue.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: DEPTH-entry operation FIFO whose head drives a combinational ALU,
// followed by a registered result stage; valid/ready handshakes on both sides.
module alu_issue_queue #(
  parameter int n     = 32,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [n-1:0]            in_a,
  input  logic [n-1:0]            in_b,
  input  logic [3:0]              in_op,
  output logic [n-1:0]            alu_a,
  output logic [n-1:0]            alu_b,
  output logic [3:0]              alu_control,
  input  logic [n-1:0]            alu_z,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [n-1:0]            out_z,
  output logic [3:0]              out_op,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [n-1:0]  a_mem_r  [DEPTH];
  logic [n-1:0]  b_mem_r  [DEPTH];
  logic [3:0]    op_mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          out_valid_r;
  logic [n-1:0]  out_z_r;
  logic [3:0]    out_op_r;

  logic          head_valid_s;
  logic          in_ready_s;
  logic          push_s;
  logic          pop_s;
  logic [CW-1:0] count_nxt_s;

  // Handshake decisions; in_ready never depends on out_ready
  always_comb begin
    head_valid_s = (count_r != {CW{1'b0}});
    in_ready_s   = (count_r < FULL_COUNT) && !flush;
    push_s       = in_valid && in_ready_s;
    pop_s        = head_valid_s && (!out_valid_r || out_ready) && !flush;
  end

  // Occupancy after this edge (simultaneous push/pop leaves it unchanged)
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Head entry presented to the ALU, zeroed when the queue is empty
  always_comb begin
    if (head_valid_s) begin
      alu_a       = a_mem_r[rd_ptr_r];
      alu_b       = b_mem_r[rd_ptr_r];
      alu_control = op_mem_r[rd_ptr_r];
    end else begin
      alu_a       = {n{1'b0}};
      alu_b       = {n{1'b0}};
      alu_control = 4'h0;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_nxt_s;
    end
  end

  // Entry storage; contents are qualified by count, so no reset is needed
  always_ff @(posedge clk) begin
    if (push_s) begin
      a_mem_r[wr_ptr_r]  <= in_a;
      b_mem_r[wr_ptr_r]  <= in_b;
      op_mem_r[wr_ptr_r] <= in_op;
    end
  end

  // Result register capturing the ALU output for the popped head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_z_r     <= {n{1'b0}};
      out_op_r    <= 4'h0;
    end else if (flush) begin
      out_valid_r <= 1'b0;
      out_z_r     <= {n{1'b0}};
      out_op_r    <= 4'h0;
    end else if (pop_s) begin
      out_valid_r <= 1'b1;
      out_z_r     <= alu_z;
      out_op_r    <= op_mem_r[rd_ptr_r];
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_z     = out_z_r;
  assign out_op    = out_op_r;
  assign count     = count_r;
endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the issue stage.
module tb_alu_issue_queue;
  localparam int N     = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [N-1:0]  in_a, in_b, alu_a, alu_b, alu_z, out_z;
  logic [3:0]    in_op, alu_control, out_op;
  logic [2:0]    count;

  always #5 clk = ~clk;
  assign alu_z = alu_a + alu_b;

  alu_issue_queue #(.n(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_z(alu_z),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_op(out_op), .count(count)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
  } op_t;

  op_t         mq[$];
  logic        m_ov;
  logic [31:0] m_z;
  logic [3:0]  m_op;
  logic        last_push;
  int          passed = 0;
  int          total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ov = 1'b0;
    m_z  = 32'h0;
    m_op = 4'h0;
  endtask

  // One clock: drive at negedge, check combinational outputs, step model, check registers
  task automatic cycle(input logic iv, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic ordy, input logic fl);
    logic m_rdy, m_push, m_pop;
    op_t  h;
    @(negedge clk);
    in_valid = iv; in_a = a; in_b = b; in_op = op; out_ready = ordy; flush = fl;
    #1;
    m_rdy = (mq.size() < DEPTH) && !fl;
    check("in_ready", {31'h0, in_ready}, {31'h0, m_rdy});
    check("alu_a", alu_a, (mq.size() != 0) ? mq[0].a : 32'h0);
    check("alu_b", alu_b, (mq.size() != 0) ? mq[0].b : 32'h0);
    check("alu_control", {28'h0, alu_control}, (mq.size() != 0) ? {28'h0, mq[0].op} : 32'h0);
    m_push = iv && m_rdy;
    m_pop  = (mq.size() != 0) && (!m_ov || ordy) && !fl;
    last_push = m_push;
    if (fl) begin
      model_reset();
    end else begin
      if (m_pop) begin
        h = mq.pop_front();
        m_ov = 1'b1;
        m_z  = h.a + h.b;
        m_op = h.op;
      end else if (m_ov && ordy) begin
        m_ov = 1'b0;
      end
      if (m_push) mq.push_back('{a: a, b: b, op: op});
    end
    @(posedge clk);
    #1;
    check("out_valid", {31'h0, out_valid}, {31'h0, m_ov});
    check("out_z", out_z, m_z);
    check("out_op", {28'h0, out_op}, {28'h0, m_op});
    check("count", {29'h0, count}, mq.size());
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 32'h0, 32'h0, 4'h0, ordy, 1'b0);
  endtask

  initial begin
    logic done5;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = 32'h0; in_b = 32'h0; in_op = 4'h0;
    model_reset();
    #12;
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_count", {29'h0, count}, 32'h0);
    check("rst_out_z", out_z, 32'h0);
    check("rst_alu_a", alu_a, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single op
    cycle(1'b1, 32'd5, 32'd3, 4'h2, 1'b1, 1'b0);
    check("single_alu_a", alu_a, 32'd5);
    idle(1'b1);
    check("single_valid", {31'h0, out_valid}, 32'h1);
    check("single_z", out_z, 32'd8);
    check("single_op", {28'h0, out_op}, 32'h2);
    idle(1'b1);
    check("single_drop", {31'h0, out_valid}, 32'h0);

    // Fill to full under backpressure, then drain in order
    for (int i = 0; i < 6; i++) cycle(1'b1, 32'(i), 32'd1, 4'(i), 1'b0, 1'b0);
    check("fill_count", {29'h0, count}, 32'd4);
    check("fill_in_ready", {31'h0, in_ready}, 32'h0);
    check("fill_head_z", out_z, 32'd1);
    done5 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle(!done5, 32'd5, 32'd1, 4'h5, 1'b1, 1'b0);
      done5 = done5 | last_push;
      check("drain_valid", {31'h0, out_valid}, 32'h1);
      check("drain_z", out_z, 32'(k + 2));
    end
    idle(1'b1);

    // Streaming at full throughput
    for (int j = 0; j < 17; j++) begin
      cycle(j < 16, 32'(j), 32'(j), 4'h1, 1'b1, 1'b0);
      check("stream_count_le1", {31'h0, (count <= 3'd1)}, 32'h1);
      if (j >= 1) check("stream_z", out_z, 32'(2 * (j - 1)));
    end
    idle(1'b1);

    // Simultaneous push/pop while full
    for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, $urandom, 4'($urandom), 1'b0, 1'b0);
    check("full_count", {29'h0, count}, 32'd4);
    cycle(1'b1, 32'd9, 32'd9, 4'h9, 1'b1, 1'b0);
    check("full_push_blocked", {31'h0, last_push}, 32'h0);
    check("full_after_count", {29'h0, count}, 32'd3);

    // Flush
    cycle(1'b1, 32'd1, 32'd1, 4'h1, 1'b0, 1'b1);
    check("flush_count", {29'h0, count}, 32'd0);
    check("flush_valid", {31'h0, out_valid}, 32'h0);
    check("flush_z", out_z, 32'd0);
    cycle(1'b1, 32'd9, 32'd1, 4'h3, 1'b1, 1'b0);
    idle(1'b1);
    check("post_flush_z", out_z, 32'd10);

    // Asynchronous reset mid-operation
    idle(1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'(i), 32'd2, 4'h7, 1'b0, 1'b0);
    check("pre_rst_count", {29'h0, count}, 32'd2);
    #2;
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    check("arst_valid", {31'h0, out_valid}, 32'h0);
    check("arst_count", {29'h0, count}, 32'h0);
    check("arst_alu_control", {28'h0, alu_control}, 32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 32'd7, 32'd7, 4'h4, 1'b1, 1'b0);
    check("post_rst_no_stale", {31'h0, out_valid}, 32'h0);
    idle(1'b1);
    check("post_rst_z", out_z, 32'd14);

    // Random traffic against the model
    for (int r = 0; r < 300; r++) begin
      cycle(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 4'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
